// File: rtl/text_sink_buffer.sv
// text_sink_buffer: final stage of the text link. Captures decompressed
// characters into a local buffer until a terminator, a full-buffer overrun,
// or the withdrawal of start_write. Provides a registered read port, the
// stored byte count and an XOR checksum of everything stored.

module text_sink_buffer #(
    parameter int         DEPTH = 32,
    parameter int         AW    = 5,
    parameter logic [7:0] TERM  = 8'h00
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          start_write,
    input  logic [7:0]    data_in,
    input  logic          data_valid,
    input  logic          clear,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [AW:0]   byte_count,
    output logic [7:0]    checksum,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic          term_seen
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    state_t      r_state;
    state_t      w_nextState;

    logic [7:0]  r_mem [DEPTH];
    logic [7:0]  r_rdData;
    logic [AW:0] r_byteCount;
    logic [7:0]  r_checksum;
    logic        r_overflow;
    logic        r_termSeen;

    logic        w_isTerm;
    logic        w_full;
    logic        w_capturing;
    logic        w_write;
    logic        w_overrun;
    logic        w_termHit;
    logic        w_clearDone;

    // Classify the incoming byte once so the state and datapath logic agree.
    always_comb begin
        w_isTerm    = (data_in == TERM);
        w_full      = (r_byteCount == FULL_COUNT);
        w_capturing = (r_state == CAPTURE) && start_write;
        w_termHit   = w_capturing && data_valid && w_isTerm;
        w_overrun   = w_capturing && data_valid && !w_isTerm && w_full;
        w_write     = w_capturing && data_valid && !w_isTerm && !w_full;
        w_clearDone = (r_state == DONE) && clear;
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state selection; the capture exits follow the priority order
    // withdrawal, terminator, overrun.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (start_write) begin
                    w_nextState = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!start_write || w_termHit || w_overrun) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (clear) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Status outputs are pure decodes of registered state and flags.
    always_comb begin
        busy       = (r_state == CAPTURE);
        done       = (r_state == DONE);
        byte_count = r_byteCount;
        checksum   = r_checksum;
        overflow   = r_overflow;
        term_seen  = r_termSeen;
        rd_data    = r_rdData;
    end

    // Count, checksum and sticky flags; clear from DONE re-arms them all.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            r_byteCount <= '0;
            r_checksum  <= '0;
            r_overflow  <= 1'b0;
            r_termSeen  <= 1'b0;
        end else if (w_clearDone) begin
            r_byteCount <= '0;
            r_checksum  <= '0;
            r_overflow  <= 1'b0;
            r_termSeen  <= 1'b0;
        end else begin
            if (w_write) begin
                r_byteCount <= r_byteCount + 1'b1;
                r_checksum  <= r_checksum ^ data_in;
            end
            if (w_overrun) begin
                r_overflow <= 1'b1;
            end
            if (w_termHit) begin
                r_termSeen <= 1'b1;
            end
        end
    end

    // Buffer storage is never reset, so stale contents survive a reset.
    always_ff @(posedge CLOCK_50) begin
        if (w_write) begin
            r_mem[r_byteCount[AW-1:0]] <= data_in;
        end
    end

    // Registered read port; a same-edge write to the same address returns
    // the old contents because the memory update is also non-blocking.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            r_rdData <= '0;
        end else begin
            r_rdData <= r_mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_text_sink_buffer.sv
// tb_text_sink_buffer: directed scoreboard bench for text_sink_buffer.
// Stimulus pushes expected status/read results into queues; a monitor on
// the falling clock edge pops and compares them.

module tb_text_sink_buffer;

    localparam int AW = 5;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic          start_write;
    logic [7:0]    data_in;
    logic          data_valid;
    logic          clear;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [AW:0]   byte_count;
    logic [7:0]    checksum;
    logic          busy;
    logic          done;
    logic          overflow;
    logic          term_seen;

    typedef struct {
        string       name;
        logic [AW:0] count;
        logic [7:0]  csum;
        logic        busy;
        logic        done;
        logic        ovf;
        logic        term;
        logic        chkRd;
        logic [7:0]  rd;
    } status_t;

    typedef struct {
        string      name;
        logic [7:0] rd;
    } read_t;

    status_t statusQ[$];
    read_t   readQ[$];
    bit      statusReq = 1'b0;
    bit      rdReq     = 1'b0;
    bit      rdReqD    = 1'b0;
    int      testsRun    = 0;
    int      testsFailed = 0;

    text_sink_buffer #(.DEPTH(32), .AW(AW), .TERM(8'h00)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .start_write (start_write),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .clear       (clear),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .byte_count  (byte_count),
        .checksum    (checksum),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .term_seen   (term_seen)
    );

    // 50 MHz-style free-running clock.
    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic void compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: pops expected values whenever a status or read result is due.
    always @(negedge CLOCK_50) begin
        status_t s;
        read_t   r;
        if (rdReqD) begin
            if (readQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL read_queue: got empty queue, expected an entry");
            end else begin
                r = readQ.pop_front();
                compare(r.name, 32'(rd_data), 32'(r.rd));
            end
        end
        rdReqD = rdReq;
        if (statusReq) begin
            if (statusQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL status_queue: got empty queue, expected an entry");
            end else begin
                s = statusQ.pop_front();
                compare({s.name, ".byte_count"}, 32'(byte_count), 32'(s.count));
                compare({s.name, ".checksum"},   32'(checksum),   32'(s.csum));
                compare({s.name, ".busy"},       32'(busy),       32'(s.busy));
                compare({s.name, ".done"},       32'(done),       32'(s.done));
                compare({s.name, ".overflow"},   32'(overflow),   32'(s.ovf));
                compare({s.name, ".term_seen"},  32'(term_seen),  32'(s.term));
                if (s.chkRd) begin
                    compare({s.name, ".rd_data"}, 32'(rd_data), 32'(s.rd));
                end
            end
        end
    end

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        data_in    = b;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [AW:0] c, input logic [7:0] cs,
                               input logic b, input logic d, input logic o, input logic t);
        status_t s;
        s.name  = name;
        s.count = c;
        s.csum  = cs;
        s.busy  = b;
        s.done  = d;
        s.ovf   = o;
        s.term  = t;
        s.chkRd = 1'b0;
        s.rd    = 8'h00;
        statusQ.push_back(s);
        statusReq = 1'b1;
        step();
        statusReq = 1'b0;
    endtask

    task automatic checkRead(input string name, input logic [AW-1:0] addr, input logic [7:0] exp);
        read_t r;
        r.name = name;
        r.rd   = exp;
        readQ.push_back(r);
        rd_addr = addr;
        rdReq   = 1'b1;
        step();
        rdReq   = 1'b0;
    endtask

    task automatic rearm();
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
    endtask

    task automatic fillBuffer();
        for (int i = 0; i < 32; i++) begin
            applyStimulus(8'(8'h41 + i));
        end
    endtask

    // Watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        status_t s;
        read_t   r;
        reset       = 1'b0;
        start_write = 1'b0;
        data_in     = 8'h00;
        data_valid  = 1'b0;
        clear       = 1'b0;
        rd_addr     = '0;

        // Reset for two cycles, then check everything is cleared.
        step();
        step();
        reset   = 1'b1;
        s.name  = "reset";
        s.count = '0;
        s.csum  = 8'h00;
        s.busy  = 1'b0;
        s.done  = 1'b0;
        s.ovf   = 1'b0;
        s.term  = 1'b0;
        s.chkRd = 1'b1;
        s.rd    = 8'h00;
        statusQ.push_back(s);
        statusReq = 1'b1;
        step();
        statusReq = 1'b0;

        // "HI" followed by the terminator.
        start_write = 1'b1;
        step();
        applyStimulus(8'h48);
        applyStimulus(8'h49);
        applyStimulus(8'h00);
        checkOutput("hi", 6'd2, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1);
        checkRead("hi_rd0", 5'd0, 8'h48);
        checkRead("hi_rd1", 5'd1, 8'h49);

        // Clear with start_write held: one IDLE cycle, then CAPTURE.
        clear = 1'b1;
        step();
        clear = 1'b0;
        checkOutput("clear_idle", 6'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("clear_capture", 6'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h5A);
        applyStimulus(8'h00);
        checkOutput("single", 6'd1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1);
        checkRead("single_rd", 5'd0, 8'h5A);

        // Fill the buffer; full alone stays in CAPTURE, the next byte overruns.
        rearm();
        fillBuffer();
        checkOutput("full", 6'd32, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h61);
        checkOutput("overflow", 6'd32, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0);
        checkRead("ovf_rd0", 5'd0, 8'h41);
        checkRead("ovf_rd31", 5'd31, 8'h60);

        // A terminator on a full buffer sets term_seen, not overflow.
        rearm();
        fillBuffer();
        applyStimulus(8'h00);
        checkOutput("full_term", 6'd32, 8'h20, 1'b0, 1'b1, 1'b0, 1'b1);

        // Withdraw start_write after three bytes; later valid bytes are ignored.
        rearm();
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h44);
        start_write = 1'b0;
        step();
        checkOutput("withdrawn", 6'd3, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h55);
        checkOutput("done_valid", 6'd3, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0);

        // IDLE ignores data; the byte on the entry edge is not stored.
        clear = 1'b1;
        step();
        clear = 1'b0;
        applyStimulus(8'h66);
        checkOutput("idle_ignore", 6'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        data_in     = 8'h77;
        data_valid  = 1'b1;
        start_write = 1'b1;
        step();
        data_valid  = 1'b0;
        checkOutput("entry_drop", 6'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        // Same-edge write and read of address 0 returns the old byte.
        r.name = "rbw_rd0";
        r.rd   = 8'h11;
        readQ.push_back(r);
        rd_addr    = 5'd0;
        rdReq      = 1'b1;
        data_in    = 8'hA1;
        data_valid = 1'b1;
        step();
        rdReq      = 1'b0;
        data_valid = 1'b0;
        applyStimulus(8'hA2);
        applyStimulus(8'hA3);

        // clear is ignored during CAPTURE.
        clear = 1'b1;
        step();
        clear = 1'b0;
        checkOutput("clear_in_capture", 6'd3, 8'hA0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hA4);
        applyStimulus(8'hA5);
        checkOutput("five", 6'd5, 8'hA1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset mid-capture; memory keeps the written bytes.
        reset = 1'b0;
        step();
        reset       = 1'b1;
        start_write = 1'b0;
        checkOutput("mid_reset", 6'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        checkRead("stale_rd2", 5'd2, 8'hA3);

        step();
        step();
        step();
        compare("status_queue_drained", 32'(statusQ.size()), 32'd0);
        compare("read_queue_drained", 32'(readQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
